cpu_trace_capture: RTL

Passive capture unit on the CPU's per-cycle fetch trace (instruction, current PC, next PC), the consuming end of the CPU's debug outputs. Arms on command, triggers on a PC match, then buffers trace records into an internal FIFO. A debug host or bench drains the FIFO over a valid/ready read port. It is used in simulation and on-board debug without perturbing the CPU.

---
 rtl/cpu_trace_pkg.sv | 33 +++
 rtl/cpu_trace_capture_if.sv | 31 +++
 rtl/trace_fifo.sv | 81 ++++++++
 rtl/cpu_trace_capture.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/cpu_trace_pkg.sv
// -----------------------------------------------------------------------------
// cpu_trace_pkg
// Shared definitions for the CPU fetch-trace capture unit.
//   state_e      capture FSM encoding (also driven out on o_state)
//   PC_STEP      sequential fetch increment
//   trace_rec_t  one buffered record, packed as {next_pc, cur_pc, instr}
//   is_discont   true when a record is not a plain sequential fetch
// -----------------------------------------------------------------------------
package cpu_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam logic [31:0] PC_STEP     = 32'd4;
  localparam int          TRACE_REC_W = 96;

  typedef struct packed {
    logic [31:0] next_pc;
    logic [31:0] cur_pc;
    logic [31:0] instr;
  } trace_rec_t;

  // Taken branch or jump: next PC is not the sequential successor (32-bit wrap).
  function automatic logic is_discont(input logic [31:0] cur_pc,
                                      input logic [31:0] next_pc);
    return (next_pc != (cur_pc + PC_STEP));
  endfunction

endpackage

// File: rtl/cpu_trace_capture_if.sv
// -----------------------------------------------------------------------------
// cpu_trace_capture_if
// Bundles the per-cycle fetch trace (CPU side) and the FWFT read port
// (host side) of the trace capture unit.
//   master : trace producer / host reader (drives trace, i_rd_ready)
//   slave  : capture unit (drives o_rd_valid and head record fields)
// -----------------------------------------------------------------------------
interface cpu_trace_capture_if;

  logic        i_trace_valid;
  logic [31:0] i_instruction;
  logic [31:0] i_cur_pc;
  logic [31:0] i_next_pc;

  logic        o_rd_valid;
  logic        i_rd_ready;
  logic [31:0] o_rd_pc;
  logic [31:0] o_rd_instr;
  logic [31:0] o_rd_next_pc;

  modport master (
    output i_trace_valid, i_instruction, i_cur_pc, i_next_pc, i_rd_ready,
    input  o_rd_valid, o_rd_pc, o_rd_instr, o_rd_next_pc
  );

  modport slave (
    input  i_trace_valid, i_instruction, i_cur_pc, i_next_pc, i_rd_ready,
    output o_rd_valid, o_rd_pc, o_rd_instr, o_rd_next_pc
  );

endinterface

// File: rtl/trace_fifo.sv
// -----------------------------------------------------------------------------
// trace_fifo
// Synchronous first-word-fall-through FIFO for trace records.
// Parameters: DEPTH (power of 2, >= 2), TRACE_REC_W (record width).
// Ports:
//   i_clk, i_arst_n     clock, async active-low reset
//   i_push, i_wr_data   write request and record
//   i_pop               read request (ignored when empty)
//   o_rd_data           head record (combinational from storage registers)
//   o_full, o_empty     occupancy flags
//   o_count             entries held (0..DEPTH)
// A push while full is accepted only when a pop happens in the same cycle.
// -----------------------------------------------------------------------------
module trace_fifo #(
  parameter  int DEPTH       = 16,
  parameter  int TRACE_REC_W = 96,
  localparam int PTR_W       = $clog2(DEPTH)
) (
  input  logic                   i_clk,
  input  logic                   i_arst_n,
  input  logic                   i_push,
  input  logic [TRACE_REC_W-1:0] i_wr_data,
  input  logic                   i_pop,
  output logic [TRACE_REC_W-1:0] o_rd_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [PTR_W:0]         o_count
);

  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_FULL = DEPTH[PTR_W:0];

  logic [TRACE_REC_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q;
  logic [PTR_W-1:0]       rd_ptr_q;
  logic [PTR_W:0]         count_q;
  logic                   do_push_s;
  logic                   do_pop_s;

  assign o_full    = (count_q == CNT_FULL);
  assign o_empty   = (count_q == {(PTR_W+1){1'b0}});
  assign o_count   = count_q;
  assign o_rd_data = mem_q[rd_ptr_q];

  // Qualify requests: pop needs data; a full FIFO only takes a push that
  // replaces the entry being popped this cycle.
  always_comb begin
    do_pop_s  = i_pop & ~o_empty;
    do_push_s = i_push & (~o_full | do_pop_s);
  end

  // Record storage; contents are don't-care until counted as valid.
  always_ff @(posedge i_clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= i_wr_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {(PTR_W+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cpu_trace_capture.sv
// -----------------------------------------------------------------------------
// cpu_trace_capture
// Passive capture unit on the CPU fetch trace. Arms on i_arm, triggers when a
// valid record's PC equals i_trig_pc, buffers records into a FWFT FIFO that a
// host drains through the read port of the cpu_trace_capture_if interface.
// Ports:
//   i_clk, i_arst_n     clock, async active-low reset
//   trc (slave)         trace inputs and FWFT read port
//   i_arm               pulse: go ARMED, clear overflow and drop count
//   i_trig_pc           trigger PC
//   i_stop              pulse: end capture (i_arm wins if both)
//   o_state             IDLE=0 ARMED=1 CAPTURE=2 DONE=3
//   o_count             FIFO entries held
//   o_overflow          sticky: a record was dropped on a full FIFO
//   o_drop_cnt          saturating count of dropped records
// Build option: define TRACE_DISCONT_ONLY_EN to keep only discontinuous
// records (taken branches/jumps) while capturing; the trigger record is
// always kept and filtered records are not drops.
// -----------------------------------------------------------------------------
module cpu_trace_capture
  import cpu_trace_pkg::*;
#(
  parameter  int DEPTH  = 16,
  parameter  int DROP_W = 16,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_arst_n,
  cpu_trace_capture_if.slave   trc,
  input  logic                 i_arm,
  input  logic [31:0]          i_trig_pc,
  input  logic                 i_stop,
  output logic [1:0]           o_state,
  output logic [PTR_W:0]       o_count,
  output logic                 o_overflow,
  output logic [DROP_W-1:0]    o_drop_cnt
);

  localparam logic [DROP_W-1:0] DROP_ONE = {{(DROP_W-1){1'b0}}, 1'b1};

  state_e            state_q;
  logic              overflow_q;
  logic [DROP_W-1:0] drop_cnt_q;

  logic       match_s;
  logic       keep_s;
  logic       wr_cand_s;
  logic       drop_s;
  logic       pop_s;
  logic       full_s;
  logic       empty_s;
  trace_rec_t wr_rec_s;
  trace_rec_t rd_rec_s;

  // Trigger detect and capture filter.
  always_comb begin
    match_s = trc.i_trace_valid && (trc.i_cur_pc == i_trig_pc);
`ifdef TRACE_DISCONT_ONLY_EN
    keep_s  = is_discont(trc.i_cur_pc, trc.i_next_pc);
`else
    keep_s  = 1'b1;
`endif
  end

  // Write candidate: trigger record in ARMED, filtered stream in CAPTURE.
  // An arm cycle re-arms only, so it never writes.
  always_comb begin
    wr_cand_s = 1'b0;
    if (i_arm) begin
      wr_cand_s = 1'b0;
    end else begin
      case (state_q)
        ST_ARMED:   wr_cand_s = match_s;
        ST_CAPTURE: wr_cand_s = trc.i_trace_valid & keep_s;
        default:    wr_cand_s = 1'b0;
      endcase
    end
  end

  // A pop frees a slot in the same cycle, so full + pop is not a drop.
  always_comb begin
    pop_s    = ~empty_s & trc.i_rd_ready;
    drop_s   = wr_cand_s & full_s & ~pop_s;
    wr_rec_s = '{next_pc: trc.i_next_pc, cur_pc: trc.i_cur_pc, instr: trc.i_instruction};
  end

  // Capture FSM; i_arm overrides everything, i_stop beats a same-cycle trigger.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q <= ST_IDLE;
    end else if (i_arm) begin
      state_q <= ST_ARMED;
    end else begin
      case (state_q)
        ST_IDLE: state_q <= ST_IDLE;
        ST_ARMED: begin
          if (i_stop) begin
            state_q <= ST_DONE;
          end else if (match_s) begin
            state_q <= ST_CAPTURE;
          end else begin
            state_q <= ST_ARMED;
          end
        end
        ST_CAPTURE: begin
          if (i_stop) begin
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_CAPTURE;
          end
        end
        ST_DONE: state_q <= ST_DONE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= {DROP_W{1'b0}};
    end else if (i_arm) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= {DROP_W{1'b0}};
    end else if (drop_s) begin
      overflow_q <= 1'b1;
      if (drop_cnt_q != {DROP_W{1'b1}}) begin
        drop_cnt_q <= drop_cnt_q + DROP_ONE;
      end
    end
  end

  trace_fifo #(
    .DEPTH       (DEPTH),
    .TRACE_REC_W (TRACE_REC_W)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_arst_n  (i_arst_n),
    .i_push    (wr_cand_s),
    .i_wr_data (wr_rec_s),
    .i_pop     (pop_s),
    .o_rd_data (rd_rec_s),
    .o_full    (full_s),
    .o_empty   (empty_s),
    .o_count   (o_count)
  );

  // Head fields are forced to zero while empty so stale storage never shows.
  assign trc.o_rd_valid   = ~empty_s;
  assign trc.o_rd_pc      = empty_s ? 32'd0 : rd_rec_s.cur_pc;
  assign trc.o_rd_instr   = empty_s ? 32'd0 : rd_rec_s.instr;
  assign trc.o_rd_next_pc = empty_s ? 32'd0 : rd_rec_s.next_pc;

  assign o_state    = state_q;
  assign o_overflow = overflow_q;
  assign o_drop_cnt = drop_cnt_q;

endmodule
